// File: rtl/dcm_clken_pkg.sv
// rtl/dcm_clken_pkg.sv - phase-shift FSM states, STATUS bit map and divide extraction for dcm_clken_gen
package dcm_clken_pkg;

    localparam int MAX_CH    = 16;
    localparam int MAX_DIV_W = 32;
    localparam int DIV_VEC_W = MAX_CH * MAX_DIV_W;

    typedef logic [1:0] ps_state_t;

    localparam ps_state_t PS_IDLE = 2'd0;
    localparam ps_state_t PS_PEND = 2'd1;
    localparam ps_state_t PS_DONE = 2'd2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_IGN  = 1;
    localparam int STAT_BAD  = 2;

    // Divide value of channel ch from the packed vector; a zero divide means divide-by-one.
    function automatic int unsigned ch_divide(input logic [DIV_VEC_W-1:0] div_vec,
                                              input int ch, input int div_w);
        logic [DIV_VEC_W-1:0] shifted;
        logic [MAX_DIV_W-1:0] mask;
        int unsigned          d;
        shifted = div_vec >> (ch * div_w);
        mask    = MAX_DIV_W'((64'd1 << div_w) - 64'd1);
        d       = shifted[MAX_DIV_W-1:0] & mask;
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/dcm_clken_chan.sv
// rtl/dcm_clken_chan.sv - one divided channel: phase counter, CLKEN/CLKDV decode and shift apply
module dcm_clken_chan #(
    parameter int          DIV_W = 8,
    parameter int unsigned DIV   = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic locked_i,
    input  logic delay_i,
    input  logic advance_i,
    output logic clken_o,
    output logic clkdv_o,
    output logic hit_o
);

    localparam int unsigned      D      = (DIV == 0) ? 1 : DIV;
    localparam logic [DIV_W-1:0] R_LAST = DIV_W'(D - 1);
    localparam logic [DIV_W-1:0] R_ADV  = (D >= 2) ? DIV_W'(D - 2) : '0;
    localparam logic [DIV_W-1:0] R_HALF = DIV_W'(D / 2);

    logic [DIV_W-1:0] r_q;
    logic [DIV_W-1:0] r_d;
    logic             hit;

    // Delay stretches the period by holding the last phase; advance shortens it by skipping it.
    always_comb begin
        r_d = '0;
        hit = 1'b0;
        if (locked_i) begin
            if (D == 1) begin
                hit = delay_i | advance_i;
            end else if (delay_i && (r_q == R_LAST)) begin
                r_d = r_q;
                hit = 1'b1;
            end else if (advance_i && (r_q == R_ADV)) begin
                r_d = '0;
                hit = 1'b1;
            end else if (r_q == R_LAST) begin
                r_d = '0;
            end else begin
                r_d = r_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign clken_o = locked_i & (r_q == '0);
    assign clkdv_o = locked_i & ((D == 1) ? 1'b1 : (r_q < R_HALF));
    assign hit_o   = hit;

endmodule

// File: rtl/dcm_clken_gen.sv
// rtl/dcm_clken_gen.sv - N-channel clock-enable generator with lock sequencing; phase shift built when DCM_CLKEN_PS_EN is defined
module dcm_clken_gen
    import dcm_clken_pkg::*;
#(
    parameter int                       NUM_CH      = 4,
    parameter int                       DIV_W       = 8,
    parameter logic [NUM_CH*DIV_W-1:0]  CH_DIVIDE   = {8'd8, 8'd4, 8'd2, 8'd1},
    parameter int                       LOCK_CYCLES = 16,
    parameter int                       SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLKIN,
    input  logic              RST,
    input  logic              PSEN,
    input  logic              PSINCDEC,
    input  logic [SEL_W-1:0]  PSSEL,
    output logic              PSDONE,
    output logic              LOCKED,
    output logic [NUM_CH-1:0] CLKEN,
    output logic [NUM_CH-1:0] CLKDV,
    output logic [7:0]        STATUS
);

    localparam int            LCW       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

    logic [LCW-1:0] lock_cnt_q;
    logic [LCW-1:0] lock_cnt_d;
    logic           locked_q;
    logic           locked_d;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        if (!locked_q) begin
            if (lock_cnt_q == LOCK_LAST) begin
                locked_d = 1'b1;
            end else begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLKIN) begin
        if (RST) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign LOCKED = locked_q;

    logic [NUM_CH-1:0] delay_v;
    logic [NUM_CH-1:0] advance_v;
    logic [NUM_CH-1:0] hit_v;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        dcm_clken_chan #(
            .DIV_W (DIV_W),
            .DIV   (ch_divide(DIV_VEC_W'(CH_DIVIDE), i, DIV_W))
        ) u_chan (
            .clk_i     (CLKIN),
            .rst_i     (RST),
            .locked_i  (locked_q),
            .delay_i   (delay_v[i]),
            .advance_i (advance_v[i]),
            .clken_o   (CLKEN[i]),
            .clkdv_o   (CLKDV[i]),
            .hit_o     (hit_v[i])
        );
    end

`ifdef DCM_CLKEN_PS_EN
    ps_state_t        ps_state_q;
    ps_state_t        ps_state_d;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    logic             dir_q;
    logic             dir_d;
    logic             ign_q;
    logic             ign_d;
    logic             bad_q;
    logic             bad_d;
    logic             sel_hit;
    logic             sel_ok;

    assign sel_ok = (int'(PSSEL) < NUM_CH);

    always_comb begin
        sel_hit   = 1'b0;
        delay_v   = '0;
        advance_v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_hit      = hit_v[i];
                delay_v[i]   = (ps_state_q == PS_PEND) && dir_q;
                advance_v[i] = (ps_state_q == PS_PEND) && !dir_q;
            end
        end
    end

    always_comb begin
        ps_state_d = ps_state_q;
        sel_d      = sel_q;
        dir_d      = dir_q;
        ign_d      = ign_q;
        bad_d      = bad_q;
        case (ps_state_q)
            PS_IDLE: begin
                if (PSEN && locked_q) begin
                    if (sel_ok) begin
                        sel_d      = PSSEL;
                        dir_d      = PSINCDEC;
                        ps_state_d = PS_PEND;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            PS_PEND: begin
                if (PSEN) begin
                    ign_d = 1'b1;
                end
                if (sel_hit) begin
                    ps_state_d = PS_DONE;
                end
            end
            PS_DONE: begin
                if (PSEN) begin
                    ign_d = 1'b1;
                end
                ps_state_d = PS_IDLE;
            end
            default: ps_state_d = PS_IDLE;
        endcase
    end

    always_ff @(posedge CLKIN) begin
        if (RST) begin
            ps_state_q <= PS_IDLE;
            sel_q      <= '0;
            dir_q      <= 1'b0;
            ign_q      <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            ps_state_q <= ps_state_d;
            sel_q      <= sel_d;
            dir_q      <= dir_d;
            ign_q      <= ign_d;
            bad_q      <= bad_d;
        end
    end

    assign PSDONE = (ps_state_q == PS_DONE);

    always_comb begin
        STATUS            = '0;
        STATUS[STAT_BUSY] = (ps_state_q == PS_PEND);
        STATUS[STAT_IGN]  = ign_q;
        STATUS[STAT_BAD]  = bad_q;
    end
`else
    logic unused_ps;

    assign delay_v   = '0;
    assign advance_v = '0;
    assign PSDONE    = 1'b0;
    assign STATUS    = '0;
    assign unused_ps = ^{PSEN, PSINCDEC, PSSEL, hit_v, PS_IDLE, PS_PEND, PS_DONE,
                         STAT_BUSY, STAT_IGN, STAT_BAD};
`endif

endmodule

// File: tb/tb_dcm_clken_gen.sv
// tb/tb_dcm_clken_gen.sv - randomized and directed bench for dcm_clken_gen against an enable-schedule model
module tb_dcm_clken_gen;

    localparam int NCH    = 4;
    localparam int LOCK_N = 16;
`ifdef DCM_CLKEN_PS_EN
    localparam bit PS_ON = 1'b1;
`else
    localparam bit PS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       psen;
    logic       psincdec;
    logic [1:0] pssel;
    logic       psdone;
    logic       locked;
    logic [3:0] clken;
    logic [3:0] clkdv;
    logic [7:0] status;

    logic       psen2;
    logic [1:0] pssel2;
    logic       psdone2;
    logic       locked2;
    logic [2:0] clken2;
    logic [2:0] clkdv2;
    logic [7:0] status2;

    dcm_clken_gen #(
        .NUM_CH(4), .DIV_W(8), .CH_DIVIDE({8'd8, 8'd4, 8'd2, 8'd1}), .LOCK_CYCLES(LOCK_N)
    ) dut (
        .CLKIN(clk), .RST(rst), .PSEN(psen), .PSINCDEC(psincdec), .PSSEL(pssel),
        .PSDONE(psdone), .LOCKED(locked), .CLKEN(clken), .CLKDV(clkdv), .STATUS(status)
    );

    dcm_clken_gen #(
        .NUM_CH(3), .DIV_W(8), .CH_DIVIDE({8'd5, 8'd3, 8'd2}), .LOCK_CYCLES(4)
    ) dut3 (
        .CLKIN(clk), .RST(rst), .PSEN(psen2), .PSINCDEC(psincdec), .PSSEL(pssel2),
        .PSDONE(psdone2), .LOCKED(locked2), .CLKEN(clken2), .CLKDV(clkdv2), .STATUS(status2)
    );

    int checks   = 0;
    int failures = 0;
    int t        = 0;
    int ps_exp   = PS_ON ? 1 : 0;

    // Model: absolute cycle numbers of each channel's enables, plus the shift window.
    int ref_div [NCH] = '{1, 2, 4, 8};
    bit rst_seen = 1'b0;
    int lock_t   = 0;
    int next_en [NCH];
    int last_en [NCH];
    int adj_t   [NCH];
    int adj_d   [NCH];
    bit busy     = 1'b0;
    int ps_c     = 0;
    int ps_done_t = 0;
    bit st_ign   = 1'b0;
    bit st_bad   = 1'b0;

    int last3 = -1;
    int last2 = -1;
    int gaps3[$];
    int gaps2[$];
    int n_psdone  = 0;
    int n_psdone3 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        bit         m_locked;
        logic [3:0] e_en;
        logic [3:0] e_dv;
        logic       e_done;
        logic [7:0] e_st;
        m_locked = rst_seen && (t >= lock_t);
        for (int i = 0; i < NCH; i++) begin
            e_en[i] = 1'b0;
            if (m_locked && t == next_en[i]) begin
                e_en[i]    = 1'b1;
                last_en[i] = t;
            end
            e_dv[i] = m_locked && (ref_div[i] == 1 || (t - last_en[i]) < ref_div[i] / 2);
        end
        e_done = busy && (t == ps_done_t);
        e_st   = {5'b0, st_bad, st_ign, (busy && t >= ps_c && t < ps_done_t)};
        if (rst_seen) begin
            chk("locked", {31'b0, locked}, {31'b0, m_locked});
            chk("clken",  {28'b0, clken},  {28'b0, e_en});
            chk("clkdv",  {28'b0, clkdv},  {28'b0, e_dv});
            chk("psdone", {31'b0, psdone}, {31'b0, e_done});
            chk("status", {24'b0, status}, {24'b0, e_st});
        end
        if (psdone === 1'b1) n_psdone++;
        if (psdone2 === 1'b1) n_psdone3++;
        if (clken[3] === 1'b1) begin
            if (last3 >= 0) gaps3.push_back(t - last3);
            last3 = t;
        end
        if (clken[2] === 1'b1) begin
            if (last2 >= 0) gaps2.push_back(t - last2);
            last2 = t;
        end
    endtask

    task automatic model_update(input logic r, input logic pe, input logic id, input logic [1:0] s);
        bit lk;
        bit in_ps;
        int ch;
        int d;
        int e;
        int delta;
        if (r) begin
            rst_seen = 1'b1;
            lock_t   = t + LOCK_N + 1;
            busy     = 1'b0;
            st_ign   = 1'b0;
            st_bad   = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                next_en[i] = lock_t;
                last_en[i] = lock_t;
                adj_t[i]   = -1;
                adj_d[i]   = 0;
            end
            return;
        end
        lk = rst_seen && (t >= lock_t);
        for (int i = 0; i < NCH; i++) begin
            if (lk && t == next_en[i]) begin
                next_en[i] = t + ref_div[i];
                if (next_en[i] == adj_t[i]) begin
                    next_en[i] = next_en[i] + adj_d[i];
                    adj_t[i]   = -1;
                end
            end
        end
        in_ps = busy && (t >= ps_c);
        if (busy && t >= ps_done_t) busy = 1'b0;
        if (PS_ON && pe && lk) begin
            if (in_ps) begin
                st_ign = 1'b1;
            end else if (int'(s) >= NCH) begin
                st_bad = 1'b1;
            end else begin
                ch   = int'(s);
                d    = ref_div[ch];
                busy = 1'b1;
                ps_c = t + 1;
                if (d == 1) begin
                    ps_done_t = t + 2;
                end else begin
                    if (id) begin
                        e         = (next_en[ch] >= t + 2) ? next_en[ch] : next_en[ch] + d;
                        ps_done_t = e;
                        delta     = 1;
                    end else begin
                        e         = (next_en[ch] >= t + 3) ? next_en[ch] : next_en[ch] + d;
                        ps_done_t = e - 1;
                        delta     = -1;
                    end
                    if (e == next_en[ch]) begin
                        next_en[ch] = next_en[ch] + delta;
                    end else begin
                        adj_t[ch] = e;
                        adj_d[ch] = delta;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic pe, input logic id, input logic [1:0] s);
        rst      = r;
        psen     = pe;
        psincdec = id;
        pssel    = s;
        check_cycle();
        model_update(r, pe, id, s);
        if (r) begin
            last3 = -1;
            last2 = -1;
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    initial begin
        logic       rpe;
        logic       rid;
        logic [1:0] rsel;
        int         n_hit;
        int         n_bad;

        rst = 1'b1; psen = 1'b0; psincdec = 1'b0; pssel = 2'd0;
        psen2 = 1'b0; pssel2 = 2'd0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 2'd0);
        while (t < 18) step(1'b0, 1'b0, 1'b0, 2'd0);
        chk("pre_lock", {27'b0, locked, clken}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 2'd0);
        chk("lock_edge", {27'b0, locked, clken}, 32'h1f);

        repeat (24) step(1'b0, 1'b0, 1'b0, 2'd0);
        n_bad = 0;
        foreach (gaps3[i]) if (gaps3[i] != 8) n_bad++;
        foreach (gaps2[i]) if (gaps2[i] != 4) n_bad++;
        chk("div_gaps", n_bad, 0);
        chk("div_gap3_seen", {31'b0, (gaps3.size() >= 2)}, 32'd1);

        gaps3.delete();
        n_psdone = 0;
        step(1'b0, 1'b1, 1'b1, 2'd3);
        repeat (30) step(1'b0, 1'b0, 1'b0, 2'd0);
        n_hit = 0; n_bad = 0;
        foreach (gaps3[i]) begin
            if (gaps3[i] == 9) n_hit++;
            else if (gaps3[i] != 8) n_bad++;
        end
        chk("delay_gap9", n_hit, ps_exp);
        chk("delay_gap_other", n_bad, 0);
        chk("delay_psdone", n_psdone, ps_exp);

        gaps2.delete();
        n_psdone = 0;
        step(1'b0, 1'b1, 1'b0, 2'd2);
        step(1'b0, 1'b1, 1'b1, 2'd0);
        repeat (20) step(1'b0, 1'b0, 1'b0, 2'd0);
        n_hit = 0; n_bad = 0;
        foreach (gaps2[i]) begin
            if (gaps2[i] == 3) n_hit++;
            else if (gaps2[i] != 4) n_bad++;
        end
        chk("adv_gap3", n_hit, ps_exp);
        chk("adv_gap_other", n_bad, 0);
        chk("adv_psdone", n_psdone, ps_exp);
        chk("ign_sticky", {31'b0, status[1]}, ps_exp);

        n_psdone3 = 0;
        psen2 = 1'b1; pssel2 = 2'd3;
        step(1'b0, 1'b0, 1'b0, 2'd0);
        psen2 = 1'b0; pssel2 = 2'd0;
        step(1'b0, 1'b0, 1'b0, 2'd0);
        chk("inst3_locked", {31'b0, locked2}, 32'd1);
        chk("bad_sel_status", {24'b0, status2}, PS_ON ? 32'h4 : 32'h0);
        repeat (10) step(1'b0, 1'b0, 1'b0, 2'd0);
        chk("bad_sel_no_done", n_psdone3, 0);

        step(1'b0, 1'b1, 1'b1, 2'd3);
        step(1'b1, 1'b0, 1'b0, 2'd0);
        chk("rst_clear", {14'b0, locked, clken, clkdv, psdone, status}, 32'h0);
        n_psdone = 0;
        repeat (40) step(1'b0, 1'b0, 1'b0, 2'd0);
        chk("rst_no_done", n_psdone, 0);
        chk("relock", {31'b0, locked}, 32'd1);

        repeat (400) begin
            rpe  = ($urandom_range(7) == 0);
            rid  = 1'($urandom_range(1));
            rsel = 2'($urandom_range(3));
            step(1'b0, rpe, rid, rsel);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcm_clken_gen.md
Name: dcm_clken_gen

Overview:
- Parametrised, synthesizable clock-enable generator for the DCM/PLL simulation layer; replaces free-running derived clocks with N enable/divided-clock channels derived from one input clock.
- Per-channel integer divide, lock sequencing, and dynamic per-channel phase shift via a PSEN/PSINCDEC/PSDONE handshake.
- Sits beside DCM_SP-style wrappers; downstream logic stays on CLKIN and qualifies with CLKEN[i].

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- DIV_W, 8, width of each divide value.
- CH_DIVIDE, {8'd8,8'd4,8'd2,8'd1}, packed NUM_CH*DIV_W initial divide per channel, channel 0 in LSBs; a value of 0 is treated as 1.
- LOCK_CYCLES, 16, CLKIN cycles from reset release to LOCKED (>=1).
- SEL_W, $clog2(NUM_CH) min 1, width of PSSEL.

Ports:
- CLKIN  input  1  sole clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- PSEN  input  1  phase-shift request strobe.
- PSINCDEC  input  1  1 = delay channel one CLKIN cycle, 0 = advance one cycle.
- PSSEL  input  SEL_W  target channel of the request.
- PSDONE  output  1  one-cycle pulse when a shift completes.
- LOCKED  output  1  outputs valid.
- CLKEN  output  NUM_CH  one-cycle enable per channel period.
- CLKDV  output  NUM_CH  divided square wave per channel.
- STATUS  output  8  [0] ps busy, [1] sticky PSEN-ignored, [2] sticky bad PSSEL, [7:3] 0.

Behaviour:
- Reset: synchronous, active-high. Each channel has phase counter r[i] in 0..D-1. At any edge with RST=1, all state clears: LOCKED=0, CLKEN=0, CLKDV=0, PSDONE=0, STATUS=0, r=0, lock counter=0, request cleared. Mid-operation reset aborts any pending shift with no PSDONE.
- Lock: after RST falls, the lock counter increments each edge. LOCKED rises at the LOCK_CYCLES-th edge and stays high until reset. While LOCKED=0, CLKEN and CLKDV are 0 and r is held at 0.
- Channels: D = divide value; D=0 is treated as 1. From the first locked cycle, r[i] counts 0..D-1 and wraps. All channels are aligned: r=0 for every channel in the first LOCKED=1 cycle.
- Channel outputs: CLKEN[i]=LOCKED & (r[i]==0). CLKDV[i]=LOCKED & (r[i] < D/2, floor). Special case: for D=1, CLKDV[i]=LOCKED. Both outputs are decoded from registers only, with no input-to-output combinational path.
- Phase-shift FSM: IDLE -> PEND -> DONE -> IDLE.
- IDLE: PSEN=1 with LOCKED=1 and PSSEL<NUM_CH latches channel and direction, then moves to PEND; STATUS[0]=1. PSEN with PSSEL>=NUM_CH sets STATUS[2] and stays IDLE. PSEN while LOCKED=0 is ignored silently.
- PEND, delay: at the edge where r==D-1, r holds at D-1 for one extra cycle (period D+1 once).
- PEND, advance: at the edge where r==D-2, r jumps to 0 (period D-1 once). For D=2, advance applies at r==0.
- PEND, D=1: no-op, completes at the next edge.
- PEND -> DONE on the modified transition edge. PSDONE=1 for exactly the DONE cycle, then IDLE; STATUS[0] clears with PSDONE.
- PSEN in PEND or DONE is ignored and sets sticky STATUS[1].

Optional Feature:
- DCM_CLKEN_PS_EN defined: phase-shift FSM, PSDONE and STATUS[2:0] are implemented as above.
- DCM_CLKEN_PS_EN undefined: the FSM is compiled out, PSEN/PSINCDEC/PSSEL are ignored, and PSDONE and STATUS are constant 0. Phases are fixed with all channels aligned.

Decomposition:
- Package dcm_clken_pkg holds the PS FSM state enum (PS_IDLE, PS_PEND, PS_DONE), STATUS bit-index constants, and a helper to extract channel i's divide from CH_DIVIDE.
- Sub-module dcm_clken_chan is one channel: r counter, CLKEN/CLKDV decode, and delay/advance apply inputs. It is generated NUM_CH times; the shared FSM and lock counter live in the top.

Test Plan:
- Lock: RST=1 for 3 cycles then 0, LOCK_CYCLES=16 -> LOCKED rises on the 16th edge; CLKEN=4'b1111 in that cycle and 0 before it.
- Divide: defaults after lock -> CLKEN[3] every 8 cycles, [2] every 4, [1] every 2, [0] every cycle; CLKDV[3] shows 4 high/4 low and CLKDV[0] is constant 1.
- Delay: PSEN=1, PSINCDEC=1, PSSEL=3 -> one CLKEN[3] gap of 9 cycles, then 8; PSDONE pulses once; STATUS[0] is high until PSDONE.
- Advance plus busy: PSINCDEC=0, PSSEL=2, with a second PSEN while pending -> one CLKEN[2] gap of 3 cycles, STATUS[1]=1, and exactly one PSDONE.
- Bad select and reset mid-shift: NUM_CH=3 with PSSEL=3 -> STATUS[2]=1 and no PSDONE. A valid PSEN followed by RST=1 before completion -> all outputs 0 next cycle and no PSDONE after relock.
- Macro off: build without DCM_CLKEN_PS_EN and drive PSEN=1 -> PSDONE=0, STATUS=0, and CLKEN periods unchanged.
